gp_timer_arbiter: RTL and testbench

- Shares one down-counting delay timer (GP_COUNT8-style datapath) between NUM_REQ requesters.
- Each requester presents a delay value and holds a request. The arbiter grants the timer round-robin, loads the delay and counts it down. It pulses a per-requester DONE on expiry, then returns the timer to the pool.
- Sits between user logic and the shared counter resource in the GreenPAK digital fabric model.

---
 rtl/gp_timer_arbiter.sv | 130 +++++++++++++
 tb/tb_gp_timer_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gp_timer_arbiter.sv
// Round-robin arbiter sharing one down-counting delay timer between NUM_REQ requesters.
// Optional macro GP_TIMER_ARBITER_KEEP_EN adds a KEEP input that freezes the running count.
module gp_timer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [NUM_REQ-1:0]         REQ,
  input  logic [NUM_REQ*WIDTH-1:0]   DELAY,
`ifdef GP_TIMER_ARBITER_KEEP_EN
  input  logic                       KEEP,
`endif
  output logic [NUM_REQ-1:0]         GNT,
  output logic [NUM_REQ-1:0]         DONE,
  output logic                       BUSY,
  output logic [WIDTH-1:0]           POUT
);

  // state | meaning
  // IDLE  | timer free, arbitrate among REQ
  // RUN   | timer granted to sel_q, counting down
  // FIN   | one-cycle DONE pulse to sel_q
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam int SW = $clog2(NUM_REQ);
  localparam logic [SW:0] NREQ_W = (SW+1)'(NUM_REQ);

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [SW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] pout_q, pout_d;

  logic [WIDTH-1:0]     delay_a [NUM_REQ];
  logic [2*NUM_REQ-1:0] req_rot;
  logic                 found;
  logic [SW-1:0]        pick;
  logic [SW-1:0]        ptr_inc;
  logic [SW:0]          sum;
  logic                 hold;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_dly
    assign delay_a[g] = DELAY[g*WIDTH +: WIDTH];
  end

`ifdef GP_TIMER_ARBITER_KEEP_EN
  assign hold = KEEP;
`else
  assign hold = 1'b0;
`endif

  // Rotate so bit 0 is the pointer position; the first set bit wins.
  always_comb begin
    req_rot = {REQ, REQ} >> ptr_q;
    found   = 1'b0;
    pick    = ptr_q;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_q} + (SW+1)'(k);
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        pick  = sum[SW-1:0];
      end
    end
  end

  always_comb begin
    if (pick == SW'(NUM_REQ - 1)) ptr_inc = '0;
    else                          ptr_inc = pick + SW'(1);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    pout_d  = pout_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_RUN;
          sel_d   = pick;
          pout_d  = delay_a[pick];
          ptr_d   = ptr_inc;
        end
      end
      S_RUN: begin
        if (!REQ[sel_q]) begin
          state_d = S_IDLE;
        end else if (hold) begin
          pout_d = pout_q;
        end else if (pout_q == '0) begin
          state_d = S_FIN;
        end else begin
          pout_d = pout_q - WIDTH'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      pout_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      pout_q  <= pout_d;
    end
  end

  // Outputs decode registered state only, never REQ or DELAY.
  always_comb begin
    GNT  = '0;
    DONE = '0;
    if (state_q == S_RUN) GNT[sel_q]  = 1'b1;
    if (state_q == S_FIN) DONE[sel_q] = 1'b1;
  end

  assign BUSY = (state_q != S_IDLE);
  assign POUT = pout_q;

endmodule

// File: tb/tb_gp_timer_arbiter.sv
// Self-checking bench for gp_timer_arbiter: per-cycle reference model plus directed literal checks.
module tb_gp_timer_arbiter;
  localparam int NR = 4;
  localparam int W  = 8;

  logic          clk;
  logic          nrst;
  logic [NR-1:0] req;
  logic [NR*W-1:0] dly;
  logic          keep;
  logic [NR-1:0] gnt, done;
  logic          busy;
  logic [W-1:0]  pout;

  int chks = 0;
  int errs = 0;
  bit en   = 0;

  gp_timer_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .CLK(clk), .nRST(nrst), .REQ(req), .DELAY(dly),
`ifdef GP_TIMER_ARBITER_KEEP_EN
    .KEEP(keep),
`endif
    .GNT(gnt), .DONE(done), .BUSY(busy), .POUT(pout)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference model: who owns the timer, who is being told it expired, remaining count.
  int m_owner = -1;
  int m_fin   = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;

  always @(posedge clk) begin
    int i;
    bit keep_eff;
`ifdef GP_TIMER_ARBITER_KEEP_EN
    keep_eff = keep;
`else
    keep_eff = 1'b0;
`endif
    if (!nrst) begin
      m_owner = -1; m_fin = -1; m_cnt = 0; m_ptr = 0;
    end else if (m_fin >= 0) begin
      m_fin = -1;
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) m_owner = -1;
      else if (keep_eff) m_cnt = m_cnt;
      else if (m_cnt == 0) begin m_fin = m_owner; m_owner = -1; end
      else m_cnt = m_cnt - 1;
    end else begin
      for (int k = 0; k < NR; k++) begin
        i = (m_ptr + k) % NR;
        if (m_owner < 0 && req[i]) begin
          m_owner = i;
          m_cnt   = int'(dly[i*W +: W]);
          m_ptr   = (i + 1) % NR;
        end
      end
    end
  end

  always @(negedge clk) begin
    int eg, ed, eb;
    if (en) begin
      eg = (m_owner >= 0) ? (1 << m_owner) : 0;
      ed = (m_fin >= 0) ? (1 << m_fin) : 0;
      eb = (m_owner >= 0 || m_fin >= 0) ? 1 : 0;
      chks++; if (int'(gnt) !== eg)  begin errs++; $display("FAIL model_gnt t=%0t: got %b expected %0b", $time, gnt, eg); end
      chks++; if (int'(done) !== ed) begin errs++; $display("FAIL model_done t=%0t: got %b expected %0b", $time, done, ed); end
      chks++; if (int'(busy) !== eb) begin errs++; $display("FAIL model_busy t=%0t: got %b expected %0d", $time, busy, eb); end
      chks++; if (int'(pout) !== m_cnt) begin errs++; $display("FAIL model_pout t=%0t: got %0d expected %0d", $time, pout, m_cnt); end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_dly(input int i, input int v);
    dly[i*W +: W] = W'(v);
  endtask

  int order [6];
  int exp_rr [6] = '{1, 2, 8, 1, 2, 8};
  int n;

  initial begin
    nrst = 0; req = '0; dly = '0; keep = 0;

    // Reset held two cycles with all requests pending.
    step(); en = 1; req = 4'b1111;
    step();
    chk("rst_gnt", 32'(gnt), 0); chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0); chk("rst_pout", 32'(pout), 0);
    nrst = 1;
    step();
    chk("rst_first_gnt", 32'(gnt), 1);
    req = 4'b0000;
    step(4);

    // Single request, delay 3; DELAY and other REQ changes mid-run are ignored.
    req = 4'b0100; set_dly(2, 3);
    step(); chk("single_gnt_c1", 32'(gnt), 4); chk("single_pout_c1", 32'(pout), 3);
    set_dly(2, 50); req = 4'b1100;
    step(); chk("single_pout_c2", 32'(pout), 2);
    req = 4'b0100;
    step(); chk("single_pout_c3", 32'(pout), 1);
    step(); chk("single_pout_c4", 32'(pout), 0); chk("single_gnt_c4", 32'(gnt), 4);
    step(); chk("single_done_c5", 32'(done), 4); chk("single_gnt_c5", 32'(gnt), 0);
    chk("single_busy_c5", 32'(busy), 1);
    req = 4'b0000;
    step(); chk("single_busy_c6", 32'(busy), 0); chk("single_done_c6", 32'(done), 0);

    // Round robin across requesters 0,1,3 with zero delays, starting from pointer 0.
    nrst = 0; step(); nrst = 1;
    dly = '0; req = 4'b1011;
    foreach (order[j]) order[j] = 0;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      step();
      if (gnt != 0) begin order[n] = int'(gnt); n++; end
    end
    req = 4'b0000;
    for (int j = 0; j < 6; j++) chk($sformatf("rr_order_%0d", j), 32'(order[j]), 32'(exp_rr[j]));
    step(3);

    // Abort: requester 1 drops REQ while POUT=6.
    set_dly(1, 10); req = 4'b0010;
    step(); chk("abort_gnt_c1", 32'(gnt), 2); chk("abort_pout_c1", 32'(pout), 10);
    step(4); chk("abort_pout_c5", 32'(pout), 6);
    req = 4'b0000;
    step(); chk("abort_gnt", 32'(gnt), 0); chk("abort_done", 32'(done), 0);
    chk("abort_busy", 32'(busy), 0); chk("abort_pout_hold", 32'(pout), 6);
    step(); chk("abort_done_late", 32'(done), 0);
    set_dly(0, 2); req = 4'b0001;
    step(); chk("after_abort_gnt", 32'(gnt), 1); chk("after_abort_pout", 32'(pout), 2);
    step(3); chk("after_abort_done", 32'(done), 1);
    req = 4'b0000;
    step(2);

    // Reset in the middle of a run for requester 3.
    set_dly(3, 9); req = 4'b1000;
    step(); chk("midrst_pout_c1", 32'(pout), 9);
    step(4); chk("midrst_pout_c5", 32'(pout), 5); chk("midrst_gnt_c5", 32'(gnt), 8);
    nrst = 0;
    step(); chk("midrst_gnt", 32'(gnt), 0); chk("midrst_done", 32'(done), 0);
    chk("midrst_busy", 32'(busy), 0); chk("midrst_pout", 32'(pout), 0);
    nrst = 1; req = 4'b1001; set_dly(0, 1); set_dly(3, 1);
    step(); chk("midrst_ptr0_gnt", 32'(gnt), 1);
    step(8);
    req = 4'b0000;
    step(3);

    // Full-range delay counts down without wrapping.
    set_dly(0, 255); req = 4'b0001;
    step(); chk("full_pout_c1", 32'(pout), 255);
    step(255); chk("full_pout_end", 32'(pout), 0); chk("full_gnt_end", 32'(gnt), 1);
    step(); chk("full_done", 32'(done), 1); chk("full_pout_fin", 32'(pout), 0);
    req = 4'b0000;
    step(3);

`ifdef GP_TIMER_ARBITER_KEEP_EN
    // KEEP freezes the count for three cycles at POUT=2.
    set_dly(0, 4); req = 4'b0001;
    step(3); chk("keep_pout_c3", 32'(pout), 2);
    keep = 1;
    step(); chk("keep_pout_c4", 32'(pout), 2);
    step(); chk("keep_pout_c5", 32'(pout), 2);
    step(); chk("keep_pout_c6", 32'(pout), 2); chk("keep_done_c6", 32'(done), 0);
    keep = 0;
    step(); chk("keep_pout_c7", 32'(pout), 1);
    step(); chk("keep_pout_c8", 32'(pout), 0);
    step(); chk("keep_done_c9", 32'(done), 1);
    req = 4'b0000;
    step(3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", chks, errs);
    $finish;
  end

endmodule
